// File: rtl/fp32_pkg.sv
// Shared fp32 constants and reducer state encoding.
package fp32_pkg;

    localparam int unsigned FP32_W  = 32;
    localparam int unsigned MAG_MSB = 30;
    localparam int unsigned MAG_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } reducer_state_t;

endpackage

// File: rtl/fp32_abs_comp.sv
// Combinational magnitude comparator: returns the fp32 operand with the smaller |x|.
// Ties keep operand a; NaN/Inf are ordered purely by bit pattern.
module fp32_abs_comp
    import fp32_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic [FP32_W-1:0] min,
    output logic              b_sel
);

    always_comb begin
        b_sel = a[MAG_MSB:MAG_LSB] > b[MAG_MSB:MAG_LSB];
        min   = b_sel ? b : a;
    end

endmodule

// File: rtl/fp32_absmin_reducer.sv
// Streaming reducer: per in_last-delimited group, emits the smallest-magnitude
// fp32 value, its index tag and a saturating beat count.
module fp32_absmin_reducer
    import fp32_pkg::*;
#(
    parameter int unsigned IDX_W = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP32_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP32_W-1:0] out_min,
    output logic [IDX_W-1:0]  out_idx,
    output logic [CNT_W-1:0]  out_count
);

    reducer_state_t    state_q, state_d;
    logic [FP32_W-1:0] best_q;
    logic [IDX_W-1:0]  best_idx_q;
    logic [CNT_W-1:0]  count_q;

    logic [FP32_W-1:0] cmp_min;
    logic              cmp_b_sel;
    logic              accept;
    logic [FP32_W-1:0] best_d;
    logic [IDX_W-1:0]  best_idx_d;
    logic [CNT_W-1:0]  count_d;

    fp32_abs_comp u_comp (
        .a     (best_q),
        .b     (in_data),
        .min   (cmp_min),
        .b_sel (cmp_b_sel)
    );

    // Handshake flags decode registered state only, so no out_ready -> in_ready path.
    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: if (accept) state_d = in_last ? HOLD : ACCUM;
            HOLD:        if (out_ready) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        best_d     = best_q;
        best_idx_d = best_idx_q;
        count_d    = count_q;
        if (state_q == IDLE) begin
            best_d     = in_data;
            best_idx_d = in_idx;
            count_d    = CNT_W'(1);
        end else begin
            best_d     = cmp_min;
            best_idx_d = cmp_b_sel ? in_idx : best_idx_q;
            count_d    = (count_q == '1) ? count_q : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q     <= '0;
            best_idx_q <= '0;
            count_q    <= '0;
            out_min    <= '0;
            out_idx    <= '0;
            out_count  <= '0;
        end else if (accept) begin
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            count_q    <= count_d;
            if (in_last) begin
                out_min   <= best_d;
                out_idx   <= best_idx_d;
                out_count <= count_d;
            end
        end
    end

endmodule
